// File: rtl/riscv_core_rf_mp.sv
// riscv_core_rf_mp
//   Integer register file: two combinational read ports, one write port,
//   and a per-register reservation scoreboard. After reset it sweeps every
//   register to zero. While the sweep runs, writes and reserves are ignored
//   and all read/pend outputs are held at zero.
// Ports
//   i_rf_clk            clock (rising edge)
//   i_rf_rst            synchronous active-high reset
//   i_rf_we3/a3/wd3     write port 3 (address 0 is never written)
//   i_rf_a1/a2          read addresses
//   i_rf_rsv/rsv_a      reserve-destination strobe and register from issue
//   o_rf_rd1/rd2        read data, with write-through bypass from port 3
//   o_rf_pend1/pend2    operand has an outstanding reservation
//   o_rf_busy           clear sweep in progress
module riscv_core_rf_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            i_rf_clk,
  input  logic            i_rf_rst,
  input  logic            i_rf_we3,
  input  logic [AW-1:0]   i_rf_a3,
  input  logic [XLEN-1:0] i_rf_wd3,
  input  logic [AW-1:0]   i_rf_a1,
  input  logic [AW-1:0]   i_rf_a2,
  input  logic            i_rf_rsv,
  input  logic [AW-1:0]   i_rf_rsv_a,
  output logic [XLEN-1:0] o_rf_rd1,
  output logic [XLEN-1:0] o_rf_rd2,
  output logic            o_rf_pend1,
  output logic            o_rf_pend2,
  output logic            o_rf_busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [NREGS-1:0]  pend;
  logic [XLEN-1:0]   rf [NREGS];

  logic ready, wr_en, rsv_en, byp1, byp2, hit1, hit2;

  assign ready  = (state == READY);
  assign wr_en  = ready && i_rf_we3 && (i_rf_a3 != '0);
  assign rsv_en = ready && i_rf_rsv && (i_rf_rsv_a != '0);

  // hitN ignores a3!=0 on purpose: pend[0] is always 0, so it cannot matter.
  assign hit1 = i_rf_we3 && (i_rf_a3 == i_rf_a1);
  assign hit2 = i_rf_we3 && (i_rf_a3 == i_rf_a2);
  assign byp1 = wr_en && (i_rf_a3 == i_rf_a1);
  assign byp2 = wr_en && (i_rf_a3 == i_rf_a2);

  // FSM, sweep counter and scoreboard.
  always_ff @(posedge i_rf_clk) begin
    if (i_rf_rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      pend    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(NREGS-1)) state <= READY;
        end
        READY: begin
          // Clear first, then set: a same-cycle reserve marks a newer producer.
          if (wr_en)  pend[i_rf_a3]    <= 1'b0;
          if (rsv_en) pend[i_rf_rsv_a] <= 1'b1;
          if (wr_en && rsv_en && (i_rf_a3 == i_rf_rsv_a)) pend[i_rf_a3] <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset of its own; the sweep zeroes it before it is visible.
  always_ff @(posedge i_rf_clk) begin
    if (!i_rf_rst) begin
      if (state == CLEAR) rf[clr_cnt] <= '0;
      else if (wr_en)     rf[i_rf_a3] <= i_rf_wd3;
    end
  end

  always_comb begin
    o_rf_rd1 = '0;
    o_rf_rd2 = '0;
    if (ready) begin
      if (byp1)                 o_rf_rd1 = i_rf_wd3;
      else if (i_rf_a1 != '0)   o_rf_rd1 = rf[i_rf_a1];
      if (byp2)                 o_rf_rd2 = i_rf_wd3;
      else if (i_rf_a2 != '0)   o_rf_rd2 = rf[i_rf_a2];
    end
  end

  assign o_rf_pend1 = ready && pend[i_rf_a1] && !hit1;
  assign o_rf_pend2 = ready && pend[i_rf_a2] && !hit2;
  assign o_rf_busy  = (state == CLEAR);

endmodule

// File: doc/riscv_core_rf_mp.md
RISCV_CORE_RF_MP -- requirements
Module: riscv_core_rf_mp

Interface
REQ-001 Parameter XLEN SHALL be: XLEN, default 64, register data width in bits.
REQ-002 Parameter NREGS SHALL be: NREGS, default 32, number of architectural registers; power of two, at least 4.
REQ-003 Parameter AW SHALL be: AW, default $clog2(NREGS), register address width.
REQ-004 The clock SHALL be: i_rf_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The reset SHALL be: i_rf_rst  input  1  synchronous, active-high reset.
REQ-006 The write enable SHALL be: i_rf_we3  input  1  write enable, write port 3.
REQ-007 The write address SHALL be: i_rf_a3  input  AW  write address.
REQ-008 The write data SHALL be: i_rf_wd3  input  XLEN  write data.
REQ-009 The read addresses SHALL be: i_rf_a1, i_rf_a2  input  AW each  read addresses, ports 1 and 2.
REQ-010 The reserve enable SHALL be: i_rf_rsv  input  1  reserve-destination strobe from issue.
REQ-011 The reserve address SHALL be: i_rf_rsv_a  input  AW  destination register being reserved.
REQ-012 The read data SHALL be: o_rf_rd1, o_rf_rd2  output  XLEN each  read data.
REQ-013 The pending flags SHALL be: o_rf_pend1, o_rf_pend2  output  1 each  operand has an outstanding reservation.
REQ-014 The busy flag SHALL be: o_rf_busy  output  1  initial clear sweep in progress.

Function
REQ-015 The block SHALL implement a 2-state FSM, CLEAR and READY; the sweep counter clr_cnt SHALL be AW bits wide.
REQ-016 In CLEAR, each cycle SHALL write 0 to rf[clr_cnt] and increment clr_cnt.
REQ-017 When clr_cnt == NREGS-1 in CLEAR, the FSM SHALL move to READY on the next edge, so the sweep takes exactly NREGS cycles.
REQ-018 READY SHALL be terminal until reset.
REQ-019 o_rf_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-020 In CLEAR, i_rf_we3 and i_rf_rsv SHALL be ignored, o_rf_rd1/2 SHALL be 0, and o_rf_pend1/2 SHALL be 0.
REQ-021 In READY, i_rf_we3=1 with i_rf_a3!=0 SHALL write i_rf_wd3 to rf[i_rf_a3] at the rising edge.
REQ-022 Writes to address 0 SHALL be dropped.
REQ-023 Reads SHALL be combinational; address 0 SHALL return 0.
REQ-024 Write-through bypass: in READY, if i_rf_we3=1, i_rf_a3!=0 and i_rf_a3==i_rf_aN, then o_rf_rdN SHALL equal i_rf_wd3 in the same cycle; otherwise o_rf_rdN SHALL equal rf[i_rf_aN].
REQ-025 Scoreboard: a per-register pend[NREGS-1:0] SHALL be kept; pend[0] SHALL be constant 0.
REQ-026 In READY, i_rf_rsv=1 with i_rf_rsv_a!=0 SHALL set pend[i_rf_rsv_a] at the edge.
REQ-027 In READY, a write to address k!=0 SHALL clear pend[k] at the edge.
REQ-028 Reserve and write to the same register in the same cycle: pend SHALL end set (reserve wins; newer producer).
REQ-029 o_rf_pendN SHALL be pend[i_rf_aN] AND NOT (i_rf_we3 AND i_rf_a3==i_rf_aN), so a same-cycle bypassed value reads as not pending.
REQ-030 The read ports SHALL be independent: both may address the same register, and both bypass simultaneously.
REQ-031 Arithmetic SHALL be limited to the clr_cnt increment (AW bits, no wrap observable, because the FSM exits at NREGS-1); there SHALL be no data arithmetic.

Reset
REQ-032 i_rf_rst=1 at an edge SHALL force FSM=CLEAR, clr_cnt=0, and pend=all 0; o_rf_busy SHALL be 1 from the following cycle.
REQ-033 Reset asserted mid-sweep or while READY SHALL restart the sweep from register 0.
REQ-034 Writes and reserves presented in a reset cycle SHALL be discarded.
REQ-035 Register contents SHALL be undefined only between reset and sweep completion, and SHALL never be visible on outputs during that window.

Verification
REQ-036 Reset sweep: pulse reset 1 cycle, NREGS=32 -> o_rf_busy=1 for exactly 32 cycles, then 0; all 32 registers read 0.
REQ-037 Write/read: write x5=0xDEAD_BEEF_0000_0001, read a1=5 the next cycle -> rd1=0xDEADBEEF00000001; write x0=0xFF -> read x0=0.
REQ-038 Bypass: same cycle we3=1, a3=7, wd3=0x1234, a1=a2=7 -> rd1=rd2=0x1234 combinationally, and pend1=pend2=0.
REQ-039 Scoreboard: reserve x9 -> pend1=1 with a1=9; write x9 on a later cycle -> pend1=0 after the edge; simultaneous reserve and write of x9 -> pend stays 1.
REQ-040 Mid-sweep reset: assert reset at sweep cycle 10 -> busy stays 1 for 32 more cycles; a write issued during the sweep is lost (reads 0 afterwards).
REQ-041 Parameter sweep: XLEN=32, NREGS=16 -> sweep lasts 16 cycles, and REQ-037/038 pass at 32-bit width.
